// File: rtl/dpram_arb_ctrl.sv
// Two-client round-robin arbiter in front of a single-port-per-direction RAM.
// Writes take two cycles end to end, reads four, with registered read capture.
module dpram_arb_ctrl #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          busy,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_waddr,
  output logic [AW-1:0] mem_raddr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_id;
  logic          r_last;
  logic [AW-1:0] r_waddr;
  logic [AW-1:0] r_raddr;
  logic [DW-1:0] r_din;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic          w_any;
  logic          w_gnt;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  // On a tie the port that did not win last time gets the grant
  assign w_any   = req0 | req1;
  assign w_gnt   = req1 & (~req0 | ~r_last);
  assign w_we    = w_gnt ? we1 : we0;
  assign w_addr  = w_gnt ? addr1 : addr0;
  assign w_wdata = w_gnt ? wdata1 : wdata0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_id     <= 1'b0;
      r_last   <= 1'b1;
      r_waddr  <= '0;
      r_raddr  <= '0;
      r_din    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_id   <= w_gnt;
            r_last <= w_gnt;
            if (w_we) begin
              r_waddr <= w_addr;
              r_din   <= w_wdata;
              r_state <= WR;
            end else begin
              r_raddr <= w_addr;
              r_state <= RD;
            end
          end
        end
        WR:   r_state <= IDLE;
        RD:   r_state <= CAP;
        CAP: begin
          if (r_id) r_rdata1 <= mem_dout;
          else      r_rdata0 <= mem_dout;
          r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign mem_wr    = (r_state == WR);
  assign mem_rd    = (r_state == RD);
  assign mem_waddr = r_waddr;
  assign mem_raddr = r_raddr;
  assign mem_din   = r_din;
  assign ack0      = (mem_wr | (r_state == DONE)) & ~r_id;
  assign ack1      = (mem_wr | (r_state == DONE)) & r_id;
  assign rvalid0   = (r_state == DONE) & ~r_id;
  assign rvalid1   = (r_state == DONE) & r_id;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;

endmodule
